// File: rtl/byte_serializer.sv
// Serializes a captured NUM_CH*BYTE_W word MSB-channel-first; `BYTE_SER_CHECKSUM_EN appends an XOR checksum byte.
// Latency: first byte 1 cycle after load, one byte per cycle when byte_ready is held; done pulses after the final accept.
// Backpressure: byte_out/byte_valid hold while byte_ready=0; load is ignored until the FIN or IDLE cycle.
module byte_serializer #(
    parameter int BYTE_W = 8,
    parameter int NUM_CH = 8,
    parameter int CNT_W  = $clog2(NUM_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [NUM_CH*BYTE_W-1:0] data_in,
    output logic [BYTE_W-1:0]        byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int WORD_W = NUM_CH * BYTE_W;
`ifdef BYTE_SER_CHECKSUM_EN
    localparam int LAST_IDX = NUM_CH;
`else
    localparam int LAST_IDX = NUM_CH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_IDX);

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [BYTE_W-1:0]   byte_out_q, byte_out_d;
    logic                byte_valid_q, byte_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic [BYTE_W-1:0]   next_byte;

`ifdef BYTE_SER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum;

    always_comb begin
        csum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            csum = csum ^ word_q[(NUM_CH-k)*BYTE_W-1 -: BYTE_W];
        end
    end
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Byte for the channel that becomes current after a handshake.
    always_comb begin
        next_byte = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cnt_inc == CNT_W'(k)) begin
                next_byte = word_q[(NUM_CH-k)*BYTE_W-1 -: BYTE_W];
            end
        end
`ifdef BYTE_SER_CHECKSUM_EN
        if (cnt_inc == CNT_W'(NUM_CH)) begin
            next_byte = csum;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            SEND: begin
                if (byte_valid_q && byte_ready) begin
                    if (cnt_q == LAST) begin
                        state_d      = FIN;
                        byte_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        cnt_d      = cnt_inc;
                        byte_out_d = next_byte;
                    end
                end
            end
            default: begin
                // FIN accepts a new word exactly like IDLE.
                if (load) begin
                    state_d      = SEND;
                    word_d       = data_in;
                    cnt_d        = '0;
                    byte_out_d   = data_in[WORD_W-1 -: BYTE_W];
                    byte_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end else begin
                    state_d      = IDLE;
                    byte_valid_d = 1'b0;
                    busy_d       = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: default 8x8 instance plus a NUM_CH=1/BYTE_W=16 instance.
module tb_byte_serializer;

    logic        clk;
    logic        rst;
    logic        load;
    logic [63:0] data_in;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;

    logic        load1;
    logic [15:0] data1;
    logic [15:0] byte_out1;
    logic        byte_valid1;
    logic        byte_ready1;
    logic        busy1;
    logic        done1;

    int n_tests;
    int n_fail;

    logic [7:0] exp_seq [8];
    logic [63:0] w_main;
    logic [63:0] w_ones;

    byte_serializer u_dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done)
    );

    byte_serializer #(.BYTE_W(16), .NUM_CH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load1),
        .data_in    (data1),
        .byte_out   (byte_out1),
        .byte_valid (byte_valid1),
        .byte_ready (byte_ready1),
        .busy       (busy1),
        .done       (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; byte_ready = 1'b1;
        tick(); tick();
        n_tests++;
        if (byte_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || byte_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_init: valid=%b busy=%b done=%b byte=%h, want 0 0 0 00", byte_valid, busy, done, byte_out);
        end
        rst = 1'b0;
        load = 1'b1; data_in = w_main; byte_ready = 1'b0;
        tick();
        load = 1'b0;
        tick();
        n_tests++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_pre: valid=%b byte=%h, want 1 01", byte_valid, byte_out);
        end
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (byte_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || byte_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b busy=%b done=%b byte=%h, want 0 0 0 00", byte_valid, busy, done, byte_out);
        end
        load = 1'b1; data_in = 64'hA1B2_C3D4_E5F6_0718;
        tick();
        load = 1'b0;
        n_tests++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hA1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reload: valid=%b busy=%b byte=%h, want 1 1 a1", byte_valid, busy, byte_out);
        end
        byte_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_drain: done=%b, want 1 within 20 cycles", done);
        end
        tick();
    endtask

    task automatic test_streaming();
        byte_ready = 1'b1;
        load = 1'b1; data_in = w_main;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (byte_out !== exp_seq[i] || byte_valid !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_byte%0d: byte=%h valid=%b busy=%b, want %h 1 1", i, byte_out, byte_valid, busy, exp_seq[i]);
            end
            tick();
        end
`ifdef BYTE_SER_CHECKSUM_EN
        n_tests++;
        if (byte_out !== 8'h00 || byte_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_csum: byte=%h valid=%b, want 00 1", byte_out, byte_valid);
        end
        tick();
`endif
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || byte_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_done: done=%b busy=%b valid=%b, want 1 0 0", done, busy, byte_valid);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || byte_out !== 8'hEF - 8'h00 && 1'b0) begin
            n_fail++;
            $display("FAIL stream_done_pulse: done=%b, want 0", done);
        end
    endtask

    task automatic test_backpressure();
        byte_ready = 1'b1;
        load = 1'b1; data_in = w_main;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                byte_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    n_tests++;
                    if (byte_out !== 8'h45 || byte_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL bp_hold%0d: byte=%h valid=%b, want 45 1", h, byte_out, byte_valid);
                    end
                    tick();
                end
                byte_ready = 1'b1;
            end
            n_tests++;
            if (byte_out !== exp_seq[i] || byte_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_byte%0d: byte=%h valid=%b, want %h 1", i, byte_out, byte_valid, exp_seq[i]);
            end
            tick();
        end
`ifdef BYTE_SER_CHECKSUM_EN
        tick();
`endif
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: done=%b busy=%b, want 1 0", done, busy);
        end
        tick();
    endtask

    task automatic test_load_during_send();
        byte_ready = 1'b1;
        load = 1'b1; data_in = w_main;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (byte_out !== exp_seq[i] || byte_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL lds_byte%0d: byte=%h valid=%b, want %h 1", i, byte_out, byte_valid, exp_seq[i]);
            end
            if (i == 3) begin
                load = 1'b1; data_in = w_ones;
            end else begin
                load = 1'b0;
            end
            tick();
        end
`ifdef BYTE_SER_CHECKSUM_EN
        n_tests++;
        if (byte_out !== 8'h00) begin
            n_fail++;
            $display("FAIL lds_csum: byte=%h, want 00", byte_out);
        end
        tick();
`endif
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL lds_fin: done=%b, want 1", done);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++;
        if (byte_out !== 8'hFF || byte_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lds_fin_load: byte=%h valid=%b busy=%b, want ff 1 1", byte_out, byte_valid, busy);
        end
        for (int i = 0; i < 20 && !done; i++) tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL lds_drain: done=%b, want 1 within 20 cycles", done);
        end
        tick();
    endtask

    task automatic test_num_ch1();
        byte_ready1 = 1'b1;
        load1 = 1'b1; data1 = 16'hBEEF;
        tick();
        load1 = 1'b0;
        n_tests++;
        if (byte_out1 !== 16'hBEEF || byte_valid1 !== 1'b1 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ch1_byte: byte=%h valid=%b busy=%b, want beef 1 1", byte_out1, byte_valid1, busy1);
        end
        tick();
`ifdef BYTE_SER_CHECKSUM_EN
        n_tests++;
        if (byte_out1 !== 16'hBEEF || byte_valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ch1_csum: byte=%h valid=%b, want beef 1", byte_out1, byte_valid1);
        end
        tick();
`endif
        n_tests++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || byte_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ch1_done: done=%b busy=%b valid=%b, want 1 0 0", done1, busy1, byte_valid1);
        end
        tick();
    endtask

`ifdef BYTE_SER_CHECKSUM_EN
    task automatic test_checksum();
        byte_ready = 1'b1;
        load = 1'b1; data_in = 64'h0000_0000_0000_0001;
        tick();
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_tests++;
            if (byte_out !== ((i >= 7) ? 8'h01 : 8'h00) || byte_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL csum_byte%0d: byte=%h valid=%b, want %h 1", i, byte_out, byte_valid, (i >= 7) ? 8'h01 : 8'h00);
            end
            tick();
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL csum_done: done=%b, want 1", done);
        end
        tick();
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_seq = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        w_main  = 64'h0123_4567_89AB_CDEF;
        w_ones  = 64'hFFFF_FFFF_FFFF_FFFF;
        rst = 1'b1; load = 1'b0; data_in = '0; byte_ready = 1'b0;
        load1 = 1'b0; data1 = '0; byte_ready1 = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_load_during_send();
        test_num_ch1();
`ifdef BYTE_SER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Parametrised successor to the team's fixed 8-channel byte selector.
- Captures one NUM_CH*BYTE_W-bit word, such as an FPU result, and emits it one BYTE_W-bit channel at a time over a valid/ready handshake, for example into the UART transmitter.
- The channel counter is internal, so the surrounding controller no longer drives a select.
- Channel 0 is the most significant byte and is sent first.

Parameters:
- BYTE_W, 8, width of one channel / output byte
- NUM_CH, 8, channels per word (>=1)
- CNT_W, $clog2(NUM_CH+1), width of the internal channel counter (derived; not overridden)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- load  input  1  request to capture data_in; accepted only when busy=0
- data_in  input  NUM_CH*BYTE_W  word; channel k = data_in[(NUM_CH-k)*BYTE_W-1 -: BYTE_W]
- byte_out  output  BYTE_W  current channel byte
- byte_valid  output  1  byte_out holds a byte to transfer
- byte_ready  input  1  consumer accepts byte_out when byte_valid=1
- busy  output  1  word transfer in progress
- done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Clocking and reset: single clock domain; all outputs registered.
- Reset:
  - state=IDLE, counter=0, word register=0.
  - byte_out=0, byte_valid=0, busy=0, done=0.
  - rst wins over every other input.
  - rst mid-transfer aborts the word: no done pulse, remaining bytes discarded.
- States: IDLE, SEND, FIN.
- IDLE:
  - busy=0, byte_valid=0.
  - load=1 captures data_in into the word register and sets counter=0.
  - Next cycle: state=SEND, busy=1, byte_valid=1, byte_out=channel 0.
  - Load-to-first-byte latency is 1 cycle.
- SEND:
  - byte_out/byte_valid stay stable until a handshake (byte_valid & byte_ready).
  - On a handshake with counter<last, counter increments and the next channel appears the following cycle with byte_valid still 1. This allows back-to-back transfers, one byte per cycle when byte_ready is held high.
  - On a handshake of the last channel: byte_valid=0 next cycle, state=FIN.
  - load is ignored in SEND; data_in changes are ignored after capture.
- FIN:
  - done=1 and busy=0 for exactly this cycle, then IDLE.
  - load=1 during FIN is accepted exactly as in IDLE.
  - Minimum spacing between words is therefore NUM_CH+1 cycles.
- Other rules:
  - byte_ready while byte_valid=0 has no effect.
  - NUM_CH=1 is supported: IDLE -> SEND (one byte) -> FIN.
  - The counter never wraps; it returns to 0 only on load or reset.
  - byte_out holds its last value when byte_valid=0.

Optional Feature:
- Macro: BYTE_SER_CHECKSUM_EN.
- Defined:
  - After the last data channel is accepted, the block emits one extra byte before FIN, with byte_valid=1.
  - That byte is the XOR of all NUM_CH captured channels, computed on the captured word.
  - The checksum byte uses the same handshake; done follows its acceptance.
  - The counter range grows to NUM_CH (CNT_W already covers it).
  - Word spacing becomes NUM_CH+2 cycles.
- Undefined: exactly NUM_CH bytes per word, no checksum logic synthesised.

Test Plan:
1. Reset:
   - Assert rst for 2 cycles mid-SEND with byte_valid=1.
   - Required: the cycle after, byte_valid=0, busy=0, done=0, byte_out=0.
   - Required: a subsequent load starts at channel 0.
2. Streaming:
   - Defaults, load data_in=64'h0123456789ABCDEF, byte_ready tied 1.
   - Required: byte_out sequence 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles starting 1 cycle after load.
   - Required: done pulses on cycle 9 with busy=0.
3. Backpressure:
   - Same word; byte_ready low for 3 cycles on channel 2, otherwise high.
   - Required: byte_out=45 held stable with byte_valid=1 for 4 cycles.
   - Required: no byte skipped or repeated; done one cycle after EF is accepted.
4. load during SEND:
   - Pulse load with data_in=64'hFFFF_FFFF_FFFF_FFFF while sending 64'h0123456789ABCDEF.
   - Required: the original 8 bytes only, unaffected.
   - Required: load asserted in the FIN cycle is accepted, and FF appears the next cycle.
5. NUM_CH=1, BYTE_W=16:
   - load 16'hBEEF, byte_ready=1.
   - Required: one BEEF transfer, done 2 cycles after load.
6. BYTE_SER_CHECKSUM_EN:
   - load 64'h0000000000000001, byte_ready=1.
   - Required: bytes 00×7, 01, then checksum 01; done after 10 cycles.
   - load 64'h0123456789ABCDEF -> checksum byte 00.
